led_pwm_fader: RTL and testbench
================================

# led_pwm_fader

Downstream output stage for the board LED blinker: consumes its 2-bit on/off LED pattern and drives the physical LED pins with PWM. The stage caps brightness at a programmable level and, optionally, ramps each channel smoothly between off and that level instead of switching hard. It sits between the pattern generator and the top-level LED pads on the 50 MHz board clock.

## Interface

Parameters:
- NCH, 2, number of LED channels.
- PWM_BITS, 8, brightness resolution; PWM period = 2^PWM_BITS − 1 clocks (255 at default).
- STEP_CYCLES, 48_828, clocks per fade step (≈0.25 s for a full 0→255 ramp at 50 MHz); must be ≥ 1.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- led_in  in  NCH  on/off request per channel from the pattern generator; same clock domain.
- level_max  in  PWM_BITS  brightness of an "on" channel; quasi-static, may change at any time.
- led_out  out  NCH  PWM drive to LED pads, active-high, registered.
- busy  out  1  high while any channel level ≠ its target.

## Operation

- led_in is registered once into led_q. Per-channel target = led_q[ch] ? level_max : 0.
- Per-channel brightness register level[ch], PWM_BITS wide, unsigned.
- Free-running pwm_cnt counts 0 … 2^PWM_BITS − 2, then wraps to 0.
- led_out[ch] <= (pwm_cnt < level[ch]); level 0 = constant off, level 2^PWM_BITS − 1 = constant on.
- Prescaler step_cnt counts 0 … STEP_CYCLES − 1; step_tick = (step_cnt == STEP_CYCLES − 1), then step_cnt wraps to 0. It runs continuously and is never restarted by input changes.
- Fade mode (see Configuration): on step_tick, each channel moves exactly 1 toward its target:
  - level < target → +1
  - level > target → −1
  - level == target → hold
- Arithmetic: compare/increment in PWM_BITS bits. Target is never exceeded, so no wrap occurs.
- Direction reversal mid-ramp, such as led_in dropping at level 5: ramp continues from the current level toward the new target. There is no jump.
- level_max lowered below the current level of an on channel: that channel ramps down to the new level_max.
- All channels step on the same tick. Opposite-direction ramps, such as the generator's 01→10 swap, produce a cross-fade.
- busy = OR over ch of (level[ch] != target[ch]), combinational from registers.

## Timing

- Reset values: led_q = 0, level = 0, pwm_cnt = 0, step_cnt = 0, led_out = 0. busy = 0.
- Reset is asynchronous and takes effect immediately mid-ramp or mid-period. First pwm_cnt increment is on the first clk edge after rst_n deasserts.
- led_in edge to led_q: 1 clk.
- Without fade: led_q to level: 1 clk. Level to led_out: 1 clk, gated by pwm_cnt position.
- With fade: the first level change occurs on the first step_tick after led_q changes. A full ramp of N levels takes N step_ticks.
- A level change takes effect on the next compare. There is no period-boundary shadowing.

## Configuration

- LED_PWM_FADE_EN defined: level ramps by ±1 per step_tick as described; the step prescaler is present.
- LED_PWM_FADE_EN undefined: level <= target every clock, which is a hard switch with 1-clk latency. The step prescaler is removed. busy is high only for the single clock between a led_q/level_max change and the level update.

## Test plan

- Reset: hold rst_n low with led_in = 2'b11 → led_out = 0, busy = 0. Release and keep led_in = 0 → led_out stays 0 indefinitely.
- No fade, level_max = 128, led_in = 2'b01 → led_out[0] high exactly 128 of every 255 clocks, led_out[1] constant 0. With level_max = 255 → led_out[0] constant 1. With level_max = 0 → constant 0.
- Fade, STEP_CYCLES = 4, level_max = 10, led_in 00→01 → level[0] reaches 10 after 10 ticks (≤ 42 clocks from the led_in edge), busy deasserts the same cycle, and level stays 10.
- Fade reversal: ramp ch0 up to level 5, then drop led_in[0] → level goes 5,4,…,0 on the next 5 ticks. It never exceeds 5.
- Cross-fade: at steady level 10 on ch0, switch led_in 01→10 → ch0 decrements and ch1 increments on the same ticks. After 10 ticks, levels = {10, 0} for {ch1, ch0}.
- Async reset mid-ramp: assert rst_n at level 6 between clock edges → level, led_out and busy are cleared immediately without a clock edge.

Source files
------------

// File: rtl/led_pwm_fader.sv
// PWM output stage for the LED pattern generator: caps brightness at level_max.
// Define LED_PWM_FADE_EN to ramp each channel by one level per step tick instead of hard switching.
module led_pwm_fader #(
    parameter int NCH         = 2,
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 48_828
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH-1:0]      led_in,
    input  logic [PWM_BITS-1:0] level_max,
    output logic [NCH-1:0]      led_out,
    output logic                busy
);
    // PWM counter wraps after 2^PWM_BITS-2 so that full scale means constant on
    localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [NCH-1:0]      led_q_reg;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [NCH-1:0]      busy_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q_reg   <= '0;
            pwm_cnt_reg <= '0;
        end else begin
            led_q_reg   <= led_in;
            pwm_cnt_reg <= (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + PWM_BITS'(1);
        end
    end

`ifdef LED_PWM_FADE_EN
    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    logic [STEP_W-1:0] step_cnt_reg;
    logic              step_tick;

    // Free-running prescaler; input changes never restart it
    assign step_tick = (step_cnt_reg == STEP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_reg <= '0;
        end else begin
            step_cnt_reg <= step_tick ? '0 : step_cnt_reg + STEP_W'(1);
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [PWM_BITS-1:0] target;
            logic [PWM_BITS-1:0] level_reg;
            logic [PWM_BITS-1:0] level_next;
            logic                led_out_reg;

            assign target       = led_q_reg[gi] ? level_max : '0;
            assign busy_vec[gi] = (level_reg != target);

`ifdef LED_PWM_FADE_EN
            // Move one step toward target; reversals continue from the current level
            always_comb begin
                level_next = level_reg;
                if (step_tick) begin
                    if (level_reg < target) begin
                        level_next = level_reg + PWM_BITS'(1);
                    end else if (level_reg > target) begin
                        level_next = level_reg - PWM_BITS'(1);
                    end
                end
            end
`else
            assign level_next = target;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    level_reg   <= '0;
                    led_out_reg <= 1'b0;
                end else begin
                    level_reg   <= level_next;
                    led_out_reg <= (pwm_cnt_reg < level_reg);
                end
            end

            assign led_out[gi] = led_out_reg;
        end
    endgenerate

    assign busy = |busy_vec;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader; fade scenarios run when LED_PWM_FADE_EN is defined.
module tb_led_pwm_fader;
    localparam int NCH         = 2;
    localparam int PWM_BITS    = 8;
    localparam int STEP_CYCLES = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NCH-1:0]      led_in = '0;
    logic [PWM_BITS-1:0] level_max = '0;
    logic [NCH-1:0]      led_out;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_pwm_fader #(
        .NCH        (NCH),
        .PWM_BITS   (PWM_BITS),
        .STEP_CYCLES(STEP_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .led_in   (led_in),
        .level_max(level_max),
        .led_out  (led_out),
        .busy     (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end else begin
            $display("ok   %s: %0d", tag, actual);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count high samples of each channel over one full PWM period
    task automatic measure(output int hi0, output int hi1);
        hi0 = 0;
        hi1 = 0;
        for (int i = 0; i < 255; i++) begin
            tick(1);
            if (led_out[0] === 1'b1) hi0++;
            if (led_out[1] === 1'b1) hi1++;
        end
    endtask

`ifdef LED_PWM_FADE_EN
    logic [PWM_BITS-1:0] lv0, lv1;
    assign lv0 = dut.g_ch[0].level_reg;
    assign lv1 = dut.g_ch[1].level_reg;

    task automatic wait_lv0(input int val, input int budget, output int cyc, output bit hit);
        cyc = 0;
        hit = (lv0 == val);
        while (!hit && cyc < budget) begin
            tick(1);
            cyc++;
            hit = (lv0 == val);
        end
    endtask
`endif

    initial begin
        int  hi0, hi1;
`ifdef LED_PWM_FADE_EN
        int  cyc, max_lv, bad_sum;
        bit  hit;
`endif
        led_in    = 2'b11;
        level_max = 8'd200;
        rst_n     = 1'b0;
        tick(3);
        check_eq("rst_led_out", led_out, 0);
        check_eq("rst_busy", busy, 0);

        led_in = 2'b00;
        rst_n  = 1'b1;
        measure(hi0, hi1);
        check_eq("idle_hi0", hi0, 0);
        check_eq("idle_hi1", hi1, 0);

`ifndef LED_PWM_FADE_EN
        level_max = 8'd128;
        led_in    = 2'b01;
        tick(1);
        check_eq("busy_on", busy, 1);
        tick(1);
        check_eq("busy_off", busy, 0);
        tick(4);
        measure(hi0, hi1);
        check_eq("duty128_ch0", hi0, 128);
        check_eq("duty128_ch1", hi1, 0);

        level_max = 8'd255;
        #1;
        check_eq("busy_lvl", busy, 1);
        tick(4);
        measure(hi0, hi1);
        check_eq("duty255_ch0", hi0, 255);

        level_max = 8'd0;
        tick(4);
        measure(hi0, hi1);
        check_eq("duty0_ch0", hi0, 0);

        level_max = 8'd64;
        led_in    = 2'b11;
        tick(4);
        measure(hi0, hi1);
        check_eq("duty64_ch0", hi0, 64);
        check_eq("duty64_ch1", hi1, 64);

        level_max = 8'd255;
        led_in    = 2'b00;
        tick(4);
        led_in = 2'b01;
        tick(2);
        check_eq("lat_2clk", led_out, 0);
        tick(1);
        check_eq("lat_3clk", led_out, 1);

        led_in = 2'b11;
        tick(1);
        check_eq("pre_rst_busy", busy, 1);
        check_eq("pre_rst_led", led_out, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_led", led_out, 0);
        check_eq("async_rst_busy", busy, 0);
        tick(1);
        rst_n = 1'b1;
`else
        level_max = 8'd10;
        led_in    = 2'b01;
        wait_lv0(10, 60, cyc, hit);
        check_eq("fade_reach", hit, 1);
        check_eq("fade_within_42", (cyc <= 42), 1);
        check_eq("fade_busy_done", busy, 0);
        tick(20);
        check_eq("fade_hold", lv0, 10);

        led_in = 2'b00;
        wait_lv0(0, 60, cyc, hit);
        check_eq("fade_down", hit, 1);

        led_in = 2'b01;
        wait_lv0(5, 60, cyc, hit);
        check_eq("rev_at5", hit, 1);
        led_in = 2'b00;
        max_lv = lv0;
        cyc    = 0;
        while (lv0 != 0 && cyc < 60) begin
            tick(1);
            cyc++;
            if (lv0 > max_lv) max_lv = lv0;
        end
        check_eq("rev_max", max_lv, 5);
        check_eq("rev_cycles", cyc, 20);

        led_in = 2'b01;
        wait_lv0(10, 60, cyc, hit);
        check_eq("xf_start", hit, 1);
        led_in  = 2'b10;
        bad_sum = 0;
        cyc     = 0;
        while (lv1 != 10 && cyc < 60) begin
            tick(1);
            cyc++;
            if (int'(lv0) + int'(lv1) != 10) bad_sum++;
        end
        check_eq("xf_cycles", cyc, 40);
        check_eq("xf_sum_errs", bad_sum, 0);
        check_eq("xf_ch0", lv0, 0);
        check_eq("xf_ch1", lv1, 10);

        led_in = 2'b01;
        wait_lv0(6, 60, cyc, hit);
        check_eq("mid_at6", hit, 1);
        check_eq("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_lv0", lv0, 0);
        check_eq("mid_rst_lv1", lv1, 0);
        check_eq("mid_rst_led", led_out, 0);
        check_eq("mid_rst_busy", busy, 0);
        tick(1);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
